pattern_delay_timer: RTL and testbench



---
 rtl/pattern_delay_timer.sv | 127 ++++++++++++
 tb/tb_pattern_delay_timer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_delay_timer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_delay_timer
// Brief    : Serial start-pattern detector, MSB-first delay capture and
//            (delay+1)*UNIT cycle countdown with done/ack handshake.
// Revision : 1.0 - initial parameterised release
// ============================================================================
module pattern_delay_timer #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PAT     = 4'b1101,
   parameter int                 DLY_W   = 4,
   parameter int                 UNIT    = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             data,
   input  logic             ack,
   output logic             shift_ena,
   output logic             counting,
   output logic             done,
   output logic [DLY_W-1:0] remaining
);

   localparam int FILL_W = $clog2(PAT_LEN + 1);
   localparam int BIT_W  = (DLY_W > 1) ? $clog2(DLY_W) : 1;
   localparam int UNIT_W = (UNIT > 1) ? $clog2(UNIT) : 1;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      SHIFT  = 2'd1,
      COUNT  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              state;
   logic [PAT_LEN-1:0]  hist;
   logic [PAT_LEN-1:0]  hist_next;
   logic [FILL_W-1:0]   fill;
   logic [FILL_W-1:0]   fill_next;
   logic [DLY_W-1:0]    delay;
   logic [DLY_W-1:0]    delay_next;
   logic [BIT_W-1:0]    bit_cnt;
   logic [UNIT_W-1:0]   unit_cnt;
   logic                match;

   // Single-bit fields cannot be sliced, so the shift paths are split by width.
   if (PAT_LEN == 1) begin : g_hist_one
      assign hist_next = data;
   end else begin : g_hist_many
      assign hist_next = {hist[PAT_LEN-2:0], data};
   end

   if (DLY_W == 1) begin : g_delay_one
      assign delay_next = data;
   end else begin : g_delay_many
      assign delay_next = {delay[DLY_W-2:0], data};
   end

   assign fill_next = (fill == FILL_W'(PAT_LEN)) ? fill : fill + 1'b1;
   assign match     = (fill_next == FILL_W'(PAT_LEN)) && (hist_next == PAT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SEARCH;
         hist      <= '0;
         fill      <= '0;
         delay     <= '0;
         bit_cnt   <= '0;
         unit_cnt  <= '0;
         remaining <= '0;
         shift_ena <= 1'b0;
         counting  <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            SEARCH: begin
               hist <= hist_next;
               fill <= fill_next;
               if (match) begin
                  state     <= SHIFT;
                  shift_ena <= 1'b1;
                  delay     <= '0;
                  remaining <= '0;
                  bit_cnt   <= '0;
               end
            end
            SHIFT: begin
               delay     <= delay_next;
               remaining <= delay_next;
               bit_cnt   <= bit_cnt + 1'b1;
               if (bit_cnt == BIT_W'(DLY_W - 1)) begin
                  state     <= COUNT;
                  shift_ena <= 1'b0;
                  counting  <= 1'b1;
                  unit_cnt  <= '0;
               end
            end
            COUNT: begin
               // remaining==0 at a unit wrap means the final unit just elapsed.
               if (unit_cnt == UNIT_W'(UNIT - 1)) begin
                  unit_cnt <= '0;
                  if (remaining == '0) begin
                     state    <= DONE;
                     counting <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     remaining <= remaining - 1'b1;
                  end
               end else begin
                  unit_cnt <= unit_cnt + 1'b1;
               end
            end
            DONE: begin
               if (ack) begin
                  state <= SEARCH;
                  done  <= 1'b0;
                  hist  <= '0;
                  fill  <= '0;
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pattern_delay_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_delay_timer
// Brief    : Directed plus random bench for two pattern_delay_timer configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_delay_timer;

   logic       clk = 1'b0;
   logic       rst0, data0, ack0, rst1, data1, ack1;
   logic       shift0, count0, done0, shift1, count1, done1;
   logic [3:0] rem0;
   logic [1:0] rem1;

   int compared = 0;
   int mismatched = 0;

   // Per-instance configuration and abstract model state.
   int c_pl[2]  = '{4, 3};
   int c_pat[2] = '{13, 0};
   int c_dw[2]  = '{4, 2};
   int c_u[2]   = '{4, 1};
   int ph[2], hv[2], hn[2], dv[2], bg[2], left[2];

   always #5 clk = ~clk;

   pattern_delay_timer #(.PAT_LEN(4), .PAT(4'b1101), .DLY_W(4), .UNIT(4)) dut0 (
      .clk(clk), .reset(rst0), .data(data0), .ack(ack0),
      .shift_ena(shift0), .counting(count0), .done(done0), .remaining(rem0)
   );

   pattern_delay_timer #(.PAT_LEN(3), .PAT(3'b000), .DLY_W(2), .UNIT(1)) dut1 (
      .clk(clk), .reset(rst1), .data(data1), .ack(ack1),
      .shift_ena(shift1), .counting(count1), .done(done1), .remaining(rem1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Phase 0=search 1=shift 2=count 3=done; history kept as a number.
   task automatic model(input int i, input logic d, input logic a, input logic r);
      if (r) begin
         ph[i] = 0; hv[i] = 0; hn[i] = 0; dv[i] = 0; bg[i] = 0; left[i] = 0;
      end else begin
         case (ph[i])
            0: begin
               hv[i] = ((hv[i] << 1) | int'(d)) & ((1 << c_pl[i]) - 1);
               if (hn[i] < c_pl[i]) hn[i]++;
               if (hn[i] == c_pl[i] && hv[i] == c_pat[i]) begin
                  ph[i] = 1; dv[i] = 0; bg[i] = 0;
               end
            end
            1: begin
               dv[i] = dv[i] * 2 + int'(d);
               bg[i]++;
               if (bg[i] == c_dw[i]) begin
                  ph[i] = 2; left[i] = (dv[i] + 1) * c_u[i];
               end
            end
            2: begin
               left[i]--;
               if (left[i] == 0) ph[i] = 3;
            end
            default: begin
               if (a) begin ph[i] = 0; hv[i] = 0; hn[i] = 0; end
            end
         endcase
      end
   endtask

   function automatic int exp_rem(input int i);
      if (ph[i] == 1) return dv[i];
      if (ph[i] == 2) return (left[i] - 1) / c_u[i];
      return 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      model(0, data0, ack0, rst0);
      model(1, data1, ack1, rst1);
      #1;
      chk("shift0", shift0, ph[0] == 1);
      chk("count0", count0, ph[0] == 2);
      chk("done0",  done0,  ph[0] == 3);
      chk("rem0",   rem0,   exp_rem(0));
      chk("shift1", shift1, ph[1] == 1);
      chk("count1", count1, ph[1] == 2);
      chk("done1",  done1,  ph[1] == 3);
      chk("rem1",   rem1,   exp_rem(1));
   endtask

   task automatic send0(input int v, input int n);
      for (int k = n - 1; k >= 0; k--) begin
         data0 = v[k];
         tick();
      end
   endtask

   // Counts cycles the counting flag stays high, bounded.
   task automatic measure(input int inst, input string tag, input int exp);
      int n = 0;
      while (((inst == 0) ? count0 : count1) === 1'b1 && n < 300) begin
         tick();
         n++;
      end
      chk(tag, n, exp);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         ph[i] = 0; hv[i] = 0; hn[i] = 0; dv[i] = 0; bg[i] = 0; left[i] = 0;
      end
      rst0 = 1; rst1 = 1; data0 = 0; ack0 = 0; data1 = 0; ack1 = 0;
      tick(); tick();
      chk("reset_outs0", {shift0, count0, done0, rem0}, 0);
      rst0 = 0; rst1 = 0;

      // Basic sequence: 1101 then delay 2.
      send0(4'b1101, 4);
      chk("t1_shift_start", shift0, 1);
      send0(4'b0010, 4);
      chk("t1_rem_start", rem0, 2);
      measure(0, "t1_count_len", 12);
      chk("t1_done_rise", done0, 1);
      repeat (4) tick();
      ack0 = 1; tick(); ack0 = 0;
      chk("t1_back_search", done0, 0);

      // Overlapping match, delay 0.
      send0(5'b11101, 5);
      chk("t2_overlap", shift0, 1);
      send0(0, 4);
      measure(0, "t3_dly0_len", 4);
      ack0 = 1; tick(); ack0 = 0;

      // False start then single match on last bit; ack held high throughout.
      send0(7'b1100110, 7);
      chk("t2_no_early", shift0, 0);
      send0(1, 1);
      chk("t2_late_match", shift0, 1);
      ack0 = 1;
      send0(4'hF, 4);
      measure(0, "t3_dlymax_len", 64);
      chk("t4_done_entry", done0, 1);
      tick();
      ack0 = 0;
      chk("t4_ack_taken", done0, 0);

      // Stale 1101 history must not combine with new 1,0,1.
      send0(3'b101, 3);
      chk("t4_stale_hist", shift0, 0);
      data0 = 0; repeat (3) tick();

      // Reset mid-count while remaining is 1.
      send0(4'b1101, 4);
      send0(4'b0001, 4);
      tick(); tick();
      chk("t5_rem_one", rem0, 1);
      rst0 = 1; tick(); rst0 = 0;
      chk("t5_reset_outs", {shift0, count0, done0, rem0}, 0);
      send0(4'b1101, 4);
      chk("t5_restart", shift0, 1);
      send0(0, 4);
      measure(0, "t5_count_len", 4);
      ack0 = 1; tick(); ack0 = 0;

      // Alternate configuration: all-zero pattern.
      rst1 = 1; tick(); rst1 = 0; data1 = 0;
      tick(); tick();
      chk("t6_two_zeros", shift1, 0);
      tick();
      chk("t6_three_zeros", shift1, 1);
      data1 = 1; tick(); tick();
      data1 = 0;
      measure(1, "t6_count_len", 4);
      ack1 = 1; tick(); ack1 = 0;

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         data0 = 1'($urandom % 2);
         ack0  = ($urandom % 4) == 0;
         rst0  = ($urandom % 300) == 0;
         data1 = ($urandom % 4) == 0;
         ack1  = ($urandom % 3) == 0;
         rst1  = ($urandom % 300) == 0;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
